// File: rtl/uart_rx_line_capture_pkg.sv
// ----------------------------------------------------------------------------
// uart_line_pkg
// Shared types and constants for the UART line feeder / line capture blocks.
//   t_uartrx_line_state : capture FSM state (2 bits)
//   c_ascii_*           : ASCII codes used by the line framing
//   f_line_preset       : spaces + CR LF preset for a line of len bytes,
//                         returned right-aligned in a 63-byte vector
//                         (byte 1 = 0x0D, byte 0 = 0x0A, bytes >= len = 0)
// ----------------------------------------------------------------------------
package uart_line_pkg;

   typedef enum logic [1:0] {
      s_idle    = 2'd0,
      s_collect = 2'd1,
      s_discard = 2'd2,
      s_publish = 2'd3
   } t_uartrx_line_state;

   localparam logic [7:0] c_ascii_cr    = 8'h0D;
   localparam logic [7:0] c_ascii_lf    = 8'h0A;
   localparam logic [7:0] c_ascii_space = 8'h20;
   localparam logic [7:0] c_ascii_bs    = 8'h08;
   localparam logic [7:0] c_ascii_del   = 8'h7F;

   localparam int c_max_line_bytes = 63;

   function automatic logic [c_max_line_bytes*8-1:0] f_line_preset(input int len);
      logic [c_max_line_bytes*8-1:0] v;
      v = '0;
      for (int i = 0; i < c_max_line_bytes; i++) begin
         if (i < len) begin
            if (i == 0)      v[i*8 +: 8] = c_ascii_lf;
            else if (i == 1) v[i*8 +: 8] = c_ascii_cr;
            else             v[i*8 +: 8] = c_ascii_space;
         end
      end
      return v;
   endfunction

endpackage

// File: rtl/uart_rx_line_capture_if.sv
// ----------------------------------------------------------------------------
// uart_rx_line_capture_if
// Byte stream from the UART RX FIFO into the line capture block.
//   i_rx_data  : received byte
//   i_rx_valid : i_rx_data holds an unread byte
//   o_rx_ready : capture can take a byte this cycle
// Handshake: a byte transfers on every rising clock edge where
// i_rx_valid && o_rx_ready; that cycle is also the pop strobe for the FIFO.
// Data must be stable while valid is high and ready is low.
// ----------------------------------------------------------------------------
interface uart_rx_line_capture_if;
   logic [7:0] i_rx_data;
   logic       i_rx_valid;
   logic       o_rx_ready;

   // master: RX FIFO side, slave: line capture side
   modport master (output i_rx_data, output i_rx_valid, input  o_rx_ready);
   modport slave  (input  i_rx_data, input  i_rx_valid, output o_rx_ready);
endinterface

// File: rtl/uart_rx_line_capture.sv
// ----------------------------------------------------------------------------
// uart_rx_line_capture
// Assembles received ASCII bytes into a fixed-width left-justified text line
// (first char in the MSB byte, space padded, CR LF in the two LSB bytes) and
// publishes it with a one-cycle pulse on a CR or LF terminator. CR LF counts
// as a single terminator. Lines longer than the payload capacity are dropped
// and flagged with an overflow pulse.
//
// Ports:
//   i_clk_40mhz      : system clock
//   i_rst_40mhz      : synchronous active-high reset
//   rx_if            : byte stream (slave modport, valid/ready)
//   o_dat_ascii_line : last completed line, held until the next publish
//   o_line_valid     : one-cycle pulse, o_dat_ascii_line updated
//   o_line_len       : payload char count of the published line
//   o_line_overflow  : one-cycle pulse, an over-long line was dropped
//   o_dbg_state      : current FSM state
//
// Optional feature macro: UART_RX_LINE_BACKSPACE_EN
//   defined   : 0x08 / 0x7F in COLLECT erase the last char
//   undefined : 0x08 / 0x7F are ordinary bytes
// ----------------------------------------------------------------------------
module uart_rx_line_capture
   import uart_line_pkg::*;
#(
   parameter int parm_ascii_line_length = 35
) (
   input  logic                                i_clk_40mhz,
   input  logic                                i_rst_40mhz,
   uart_rx_line_capture_if.slave               rx_if,
   output logic [parm_ascii_line_length*8-1:0] o_dat_ascii_line,
   output logic                                o_line_valid,
   output logic [5:0]                          o_line_len,
   output logic                                o_line_overflow,
   output t_uartrx_line_state                  o_dbg_state
);

   localparam int         c_l  = parm_ascii_line_length;
   localparam int         c_lw = c_l * 8;
   localparam logic [5:0] c_p  = 6'(c_l - 2);

   t_uartrx_line_state r_state;
   logic [5:0]         r_k;
   logic               r_cr_seen;
   logic [c_lw-1:0]    r_buf;
   logic [c_lw-1:0]    r_line;
   logic [5:0]         r_len;
   logic               r_line_valid;
   logic               r_overflow;

   t_uartrx_line_state w_state_nxt;
   logic [5:0]         w_k_nxt;
   logic               w_cr_nxt;
   logic [c_lw-1:0]    w_buf_nxt;
   logic [c_lw-1:0]    w_line_nxt;
   logic [5:0]         w_len_nxt;
   logic               w_valid_nxt;
   logic               w_ovf_nxt;

   logic [c_max_line_bytes*8-1:0] w_preset_full;
   logic [c_lw-1:0]               w_preset;
   logic                          w_accept;
   logic                          w_is_term;
   logic                          w_is_bs;
   int                            w_slot;

   assign w_preset_full = f_line_preset(c_l);
   assign w_preset      = w_preset_full[c_lw-1:0];

   assign rx_if.o_rx_ready = (r_state != s_publish);
   assign w_accept  = rx_if.i_rx_valid && rx_if.o_rx_ready;
   assign w_is_term = (rx_if.i_rx_data == c_ascii_cr) || (rx_if.i_rx_data == c_ascii_lf);

`ifdef UART_RX_LINE_BACKSPACE_EN
   assign w_is_bs = (rx_if.i_rx_data == c_ascii_bs) || (rx_if.i_rx_data == c_ascii_del);
`else
   assign w_is_bs = 1'b0;
`endif

   // Byte slot of the next char, counted from the LSB byte.
   assign w_slot = c_l - 1 - int'(r_k);

   always_comb begin
      w_state_nxt = r_state;
      w_k_nxt     = r_k;
      w_cr_nxt    = r_cr_seen;
      w_buf_nxt   = r_buf;
      w_line_nxt  = r_line;
      w_len_nxt   = r_len;
      w_valid_nxt = 1'b0;
      w_ovf_nxt   = 1'b0;

      if (r_state == s_publish) begin
         w_state_nxt = s_idle;
         w_buf_nxt   = w_preset;
         w_k_nxt     = '0;
      end else if (w_accept) begin
         w_cr_nxt = (rx_if.i_rx_data == c_ascii_cr);
         if ((rx_if.i_rx_data == c_ascii_lf) && r_cr_seen) begin
            // LF of a CR LF pair: the CR already terminated the line
         end else if (w_is_term) begin
            case (r_state)
               s_collect: begin
                  w_state_nxt = s_publish;
                  w_line_nxt  = r_buf;
                  w_len_nxt   = r_k;
                  w_valid_nxt = 1'b1;
               end
               s_discard: begin
                  w_state_nxt = s_idle;
                  w_ovf_nxt   = 1'b1;
                  w_buf_nxt   = w_preset;
                  w_k_nxt     = '0;
               end
               default: ;
            endcase
         end else if (w_is_bs) begin
            if (r_state == s_collect) begin
               w_buf_nxt[8*(w_slot+1) +: 8] = c_ascii_space;
               w_k_nxt = r_k - 6'd1;
               if (r_k == 6'd1) w_state_nxt = s_idle;
            end
         end else begin
            if ((r_state == s_idle) || ((r_state == s_collect) && (r_k < c_p))) begin
               w_buf_nxt[8*w_slot +: 8] = rx_if.i_rx_data;
               w_k_nxt     = r_k + 6'd1;
               w_state_nxt = s_collect;
            end else if (r_state == s_collect) begin
               // line full: hold K and buffer, drop the rest of the line
               w_state_nxt = s_discard;
            end
         end
      end
   end

   always_ff @(posedge i_clk_40mhz) begin
      if (i_rst_40mhz) begin
         r_state      <= s_idle;
         r_k          <= '0;
         r_cr_seen    <= 1'b0;
         r_buf        <= w_preset;
         r_line       <= w_preset;
         r_len        <= '0;
         r_line_valid <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_k          <= w_k_nxt;
         r_cr_seen    <= w_cr_nxt;
         r_buf        <= w_buf_nxt;
         r_line       <= w_line_nxt;
         r_len        <= w_len_nxt;
         r_line_valid <= w_valid_nxt;
         r_overflow   <= w_ovf_nxt;
      end
   end

   assign o_dat_ascii_line = r_line;
   assign o_line_valid     = r_line_valid;
   assign o_line_len       = r_len;
   assign o_line_overflow  = r_overflow;
   assign o_dbg_state      = r_state;

endmodule
